// File: rtl/minimac_slot_ctrl.sv
// rtl/minimac_slot_ctrl.sv - receive slot manager, in-order completion queue and transmit handshake
module minimac_slot_ctrl #(
    parameter int SLOT_BITS = 1,
    parameter int CW        = 11
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          arm_valid,
    input  logic [SLOT_BITS-1:0]          arm_slot,
    output logic [2**SLOT_BITS-1:0]       rx_ready,
    input  logic [2**SLOT_BITS-1:0]       rx_done,
    input  logic [(2**SLOT_BITS)*CW-1:0]  rx_count,
    output logic                          cpl_valid,
    output logic [SLOT_BITS-1:0]          cpl_slot,
    output logic [CW-1:0]                 cpl_count,
    input  logic                          cpl_ack,
    input  logic                          tx_req,
    input  logic [CW-1:0]                 tx_len,
    output logic                          phy_tx_start,
    output logic [CW-1:0]                 phy_tx_count,
    input  logic                          phy_tx_done,
    output logic                          tx_busy,
    output logic                          tx_event,
    output logic                          err_arm,
    output logic                          err_spurious,
    input  logic                          err_clr,
    output logic                          irq
);
    localparam int NSLOTS = 2**SLOT_BITS;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_ARMED,
        SLOT_PEND,
        SLOT_QUEUED
    } slot_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    slot_state_t          slot_q    [NSLOTS];
    slot_state_t          slot_next [NSLOTS];
    logic [CW-1:0]        count_q   [NSLOTS];
    logic [SLOT_BITS-1:0] fifo_mem  [NSLOTS];
    logic [SLOT_BITS:0]   wr_ptr;
    logic [SLOT_BITS:0]   rd_ptr;
    logic [SLOT_BITS-1:0] head_slot;
    logic [SLOT_BITS-1:0] push_idx;
    logic                 push_valid;
    logic                 pop;
    logic                 arm_err_evt;
    logic                 spur_rx;
    logic                 spur_tx;

    tx_state_t            tx_state_q;
    tx_state_t            tx_state_d;
    logic                 tx_accept;
    logic                 tx_finish;

    // Extra pointer bit separates full from empty.
    assign head_slot = fifo_mem[rd_ptr[SLOT_BITS-1:0]];
    assign cpl_valid = (wr_ptr != rd_ptr);
    assign pop       = cpl_valid & cpl_ack;
    assign cpl_slot  = cpl_valid ? head_slot : '0;
    assign cpl_count = cpl_valid ? count_q[head_slot] : '0;
    assign tx_busy   = (tx_state_q == TX_BUSY);
    assign spur_tx   = phy_tx_done & (tx_state_q == TX_IDLE);
    assign irq       = cpl_valid | tx_event;

    always_comb begin
        for (int i = 0; i < NSLOTS; i++) begin
            rx_ready[i] = (slot_q[i] == SLOT_ARMED);
        end
    end

    // Lowest-index pending slot wins the single push per cycle.
    always_comb begin
        push_valid = 1'b0;
        push_idx   = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (slot_q[i] == SLOT_PEND) begin
                push_valid = 1'b1;
                push_idx   = SLOT_BITS'(i);
            end
        end
    end

    always_comb begin
        slot_next   = slot_q;
        arm_err_evt = 1'b0;
        spur_rx     = 1'b0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (rx_done[i]) begin
                if (slot_q[i] == SLOT_ARMED) begin
                    slot_next[i] = SLOT_PEND;
                end else begin
                    spur_rx = 1'b1;
                end
            end
        end
        if (push_valid) begin
            slot_next[push_idx] = SLOT_QUEUED;
        end
        if (pop) begin
            slot_next[head_slot] = SLOT_FREE;
        end
        // A slot being released this cycle may be re-armed at once.
        if (arm_valid) begin
            if (slot_q[arm_slot] == SLOT_FREE || (pop && head_slot == arm_slot)) begin
                slot_next[arm_slot] = SLOT_ARMED;
            end else begin
                arm_err_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NSLOTS; i++) begin
                slot_q[i] <= SLOT_FREE;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            slot_q <= slot_next;
            if (push_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < NSLOTS; i++) begin
            if (rx_done[i] && slot_q[i] == SLOT_ARMED) begin
                count_q[i] <= rx_count[i*CW +: CW];
            end
        end
        if (push_valid) begin
            fifo_mem[wr_ptr[SLOT_BITS-1:0]] <= push_idx;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_accept  = 1'b0;
        tx_finish  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_req && tx_len != '0) begin
                    tx_state_d = TX_BUSY;
                    tx_accept  = 1'b1;
                end
            end
            TX_BUSY: begin
                if (phy_tx_done) begin
                    tx_state_d = TX_IDLE;
                    tx_finish  = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_state_q   <= TX_IDLE;
            phy_tx_start <= 1'b0;
            phy_tx_count <= '0;
            tx_event     <= 1'b0;
            err_arm      <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            phy_tx_start <= tx_accept;
            tx_event     <= tx_finish;
            if (tx_accept) begin
                phy_tx_count <= tx_len;
            end
            // New error events take priority over clear.
            err_arm      <= arm_err_evt | (err_arm & ~err_clr);
            err_spurious <= spur_rx | spur_tx | (err_spurious & ~err_clr);
        end
    end
endmodule

// File: tb/tb_minimac_slot_ctrl.sv
// tb/tb_minimac_slot_ctrl.sv - directed self-checking bench for minimac_slot_ctrl
module tb_minimac_slot_ctrl;
    localparam int SB = 2;
    localparam int CW = 11;
    localparam int NS = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              arm_valid;
    logic [SB-1:0]     arm_slot;
    logic [NS-1:0]     rx_ready;
    logic [NS-1:0]     rx_done;
    logic [NS*CW-1:0]  rx_count;
    logic              cpl_valid;
    logic [SB-1:0]     cpl_slot;
    logic [CW-1:0]     cpl_count;
    logic              cpl_ack;
    logic              tx_req;
    logic [CW-1:0]     tx_len;
    logic              phy_tx_start;
    logic [CW-1:0]     phy_tx_count;
    logic              phy_tx_done;
    logic              tx_busy;
    logic              tx_event;
    logic              err_arm;
    logic              err_spurious;
    logic              err_clr;
    logic              irq;

    int tests_run    = 0;
    int tests_failed = 0;

    minimac_slot_ctrl #(.SLOT_BITS(SB), .CW(CW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .arm_valid(arm_valid), .arm_slot(arm_slot), .rx_ready(rx_ready),
        .rx_done(rx_done), .rx_count(rx_count),
        .cpl_valid(cpl_valid), .cpl_slot(cpl_slot), .cpl_count(cpl_count), .cpl_ack(cpl_ack),
        .tx_req(tx_req), .tx_len(tx_len), .phy_tx_start(phy_tx_start),
        .phy_tx_count(phy_tx_count), .phy_tx_done(phy_tx_done),
        .tx_busy(tx_busy), .tx_event(tx_event),
        .err_arm(err_arm), .err_spurious(err_spurious), .err_clr(err_clr), .irq(irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic arm(input int s);
        arm_valid = 1'b1;
        arm_slot  = SB'(s);
        tick();
        arm_valid = 1'b0;
    endtask

    task automatic done(input logic [NS-1:0] mask, input logic [CW-1:0] cnt);
        rx_done  = mask;
        rx_count = {NS{cnt}};
        tick();
        rx_done  = '0;
    endtask

    task automatic ack();
        cpl_ack = 1'b1;
        tick();
        cpl_ack = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1; arm_valid = 1'b0; arm_slot = '0; rx_done = '0; rx_count = '0;
        cpl_ack = 1'b0; tx_req = 1'b0; tx_len = '0; phy_tx_done = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        check("rst_rx_ready", rx_ready, 0);
        check("rst_cpl_valid", cpl_valid, 0);
        check("rst_cpl_slot", cpl_slot, 0);
        check("rst_cpl_count", cpl_count, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_count", phy_tx_count, 0);
        check("rst_errs", {err_arm, err_spurious}, 0);
        check("rst_irq", irq, 0);

        // single frame through slot 2
        arm(2);
        check("t1_ready", rx_ready, 4'b0100);
        done(4'b0100, 11'h05E);
        check("t1_pend_valid", cpl_valid, 0);
        check("t1_pend_ready", rx_ready, 0);
        tick();
        check("t1_valid", cpl_valid, 1);
        check("t1_slot", cpl_slot, 2);
        check("t1_count", cpl_count, 11'h05E);
        check("t1_irq", irq, 1);
        ack();
        check("t1_popped", cpl_valid, 0);
        arm(2);
        check("t1_rearm", rx_ready, 4'b0100);
        check("t1_no_err", err_arm, 0);
        done(4'b0100, 11'd7);
        tick();
        ack();

        // simultaneous dones drain in ascending order
        for (int s = 0; s < NS; s++) arm(s);
        check("t2_all_ready", rx_ready, 4'b1111);
        check("t2_no_err", err_arm, 0);
        rx_done = 4'b1010;
        rx_count = '0;
        rx_count[1*CW +: CW] = 11'd100;
        rx_count[3*CW +: CW] = 11'd200;
        tick();
        rx_done = '0;
        tick();
        check("t2_h0_slot", cpl_slot, 1);
        check("t2_h0_count", cpl_count, 100);
        tick();
        done(4'b0001, 11'h033);
        check("t2_ready", rx_ready, 4'b0100);
        check("t2_h1_slot", cpl_slot, 1);
        ack();
        check("t2_h2_valid", cpl_valid, 1);
        check("t2_h2_slot", cpl_slot, 3);
        check("t2_h2_count", cpl_count, 200);
        ack();
        check("t2_h3_valid", cpl_valid, 1);
        check("t2_h3_slot", cpl_slot, 0);
        check("t2_h3_count", cpl_count, 11'h033);
        ack();
        check("t2_empty", cpl_valid, 0);

        // error flags
        arm(0);
        arm(0);
        check("t3_err_arm", err_arm, 1);
        check("t3_still_armed", rx_ready, 4'b0101);
        done(4'b0010, 11'd9);
        check("t3_err_spur", err_spurious, 1);
        tick();
        check("t3_no_entry", cpl_valid, 0);
        err_clr = 1'b1;
        arm(0);
        err_clr = 1'b0;
        check("t3_set_wins", err_arm, 1);
        check("t3_spur_clr", err_spurious, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_arm_clr", err_arm, 0);

        // pop and re-arm of the same slot in one cycle
        done(4'b0001, 11'h011);
        tick();
        check("t4_head", cpl_slot, 0);
        cpl_ack = 1'b1;
        arm(0);
        cpl_ack = 1'b0;
        check("t4_popped", cpl_valid, 0);
        check("t4_rearmed", rx_ready, 4'b0101);
        check("t4_no_err", err_arm, 0);
        arm(1);
        arm(3);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (r + k) % NS;
                done(NS'(1 << s), CW'(r * 40 + s * 3 + 5));
            end
            tick();
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (r + k) % NS;
                check($sformatf("t4_r%0d_slot%0d", r, k), cpl_slot, s);
                check($sformatf("t4_r%0d_cnt%0d", r, k), cpl_count, r * 40 + s * 3 + 5);
                ack();
            end
            check($sformatf("t4_r%0d_empty", r), cpl_valid, 0);
            for (int s = 0; s < NS; s++) arm(s);
        end
        check("t4_err", {err_arm, err_spurious}, 0);

        // transmit handshake
        tx_req = 1'b1; tx_len = 11'd1514;
        tick();
        tx_req = 1'b0;
        check("t5_start", phy_tx_start, 1);
        check("t5_busy", tx_busy, 1);
        check("t5_count", phy_tx_count, 1514);
        tx_req = 1'b1; tx_len = 11'd60;
        tick();
        tx_req = 1'b0;
        check("t5_start_once", phy_tx_start, 0);
        check("t5_count_held", phy_tx_count, 1514);
        check("t5_still_busy", tx_busy, 1);
        phy_tx_done = 1'b1;
        tick();
        phy_tx_done = 1'b0;
        check("t5_event", tx_event, 1);
        check("t5_irq", irq, 1);
        check("t5_idle", tx_busy, 0);
        tick();
        check("t5_event_pulse", tx_event, 0);
        check("t5_irq_drop", irq, 0);
        tx_req = 1'b1; tx_len = '0;
        tick();
        tx_req = 1'b0;
        check("t5_zero_start", phy_tx_start, 0);
        check("t5_zero_busy", tx_busy, 0);
        tx_req = 1'b1; tx_len = 11'd60;
        tick();
        tx_req = 1'b0;
        check("t5_restart", phy_tx_count, 60);

        // reset mid-operation
        done(4'b0011, 11'd42);
        tick();
        tick();
        check("t6_queued", cpl_valid, 1);
        check("t6_busy", tx_busy, 1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("t6_rx_ready", rx_ready, 0);
        check("t6_cpl_valid", cpl_valid, 0);
        check("t6_cpl_slot", cpl_slot, 0);
        check("t6_cpl_count", cpl_count, 0);
        check("t6_tx_busy", tx_busy, 0);
        check("t6_tx_count", phy_tx_count, 0);
        check("t6_irq", irq, 0);
        phy_tx_done = 1'b1;
        tick();
        phy_tx_done = 1'b0;
        check("t6_spur", err_spurious, 1);
        check("t6_no_event", tx_event, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/minimac_slot_ctrl.md
Name: minimac_slot_ctrl

Overview:
System-clock-side controller for the MAC receive slots and the transmit handshake. It is a parametrised successor of the fixed two-slot ready/done/count exchange.
- Manages 2**SLOT_BITS receive slots with per-slot free/armed/pending/queued state.
- Orders completed frames through an in-order completion queue with a valid/ack interface.
- Runs the single-transmit start/done handshake and provides sticky error flags.
- All MAC-side signals arrive already synchronised into sys_clk; the CDC cells sit outside this block.

Parameters:
SLOT_BITS, 1, log2 of slot count; NSLOTS = 2**SLOT_BITS (derived, 2..16 supported).
CW, 11, frame byte-count width.

Ports:
sys_clk  in  1  system clock; sole clock.
sys_rst  in  1  synchronous active-high reset.
arm_valid  in  1  request to arm slot arm_slot.
arm_slot  in  SLOT_BITS  slot index to arm.
rx_ready  out  NSLOTS  level per slot, high while slot is ARMED.
rx_done  in  NSLOTS  one-cycle pulse per slot from MAC: frame written.
rx_count  in  NSLOTS*CW  flat per-slot byte counts; slot i at bits [i*CW +: CW], valid with rx_done[i].
cpl_valid  out  1  completion queue non-empty.
cpl_slot  out  SLOT_BITS  slot index at queue head.
cpl_count  out  CW  latched byte count of head slot.
cpl_ack  in  1  pops head when cpl_valid.
tx_req  in  1  start transmit of tx_len bytes.
tx_len  in  CW  transmit length.
phy_tx_start  out  1  one-cycle start pulse to MAC.
phy_tx_count  out  CW  latched transmit length, stable while tx_busy.
phy_tx_done  in  1  one-cycle pulse from MAC: transmit finished.
tx_busy  out  1  transmit in flight.
tx_event  out  1  one-cycle pulse on transmit completion.
err_arm  out  1  sticky: arm of non-FREE slot.
err_spurious  out  1  sticky: rx_done on non-ARMED slot, or phy_tx_done while idle.
err_clr  in  1  clears both sticky errors.
irq  out  1  cpl_valid OR tx_event.

Behaviour:
- Reset: every slot FREE, queue empty, TX IDLE. All outputs 0, including phy_tx_count, cpl_slot and cpl_count.
- Slot FSM, per slot i:
  - FREE -> ARMED on arm_valid with arm_slot==i. rx_ready[i] goes high the cycle after arm.
  - arm of an ARMED, PEND or QUEUED slot: ignored; err_arm sets.
  - ARMED -> PEND on rx_done[i]. rx_count slice i is latched into count[i] on the same edge, and rx_ready[i] drops the next cycle.
  - rx_done[i] in any other state: ignored, count not latched; err_spurious sets.
  - PEND -> QUEUED: each cycle the lowest-index PEND slot is pushed to the queue tail. Only one push per cycle; simultaneous dones drain in ascending index order over successive cycles.
  - QUEUED -> FREE when it is the queue head and cpl_valid&cpl_ack.
  - Arm of the slot being popped in the same cycle is accepted: the slot goes directly to ARMED, with no error.
- Completion queue: circular FIFO, depth NSLOTS, SLOT_BITS-wide entries.
  - It cannot overflow because each slot occupies at most one entry.
  - Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo NSLOTS; an extra wrap bit (or an occupancy counter of SLOT_BITS+1 bits) distinguishes full from empty.
  - cpl_count = count[cpl_slot]. Head outputs hold stable until ack.
  - Latency: rx_done at edge t, queue empty, no other PEND slots -> cpl_valid high after edge t+1.
- TX FSM: IDLE, BUSY.
  - IDLE & tx_req & tx_len!=0 -> BUSY. phy_tx_count <= tx_len; phy_tx_start is high for exactly the following cycle.
  - tx_req with tx_len==0: ignored.
  - tx_req while BUSY: ignored; phy_tx_count is unchanged.
  - BUSY & phy_tx_done -> IDLE, with tx_event high for one cycle.
  - phy_tx_done in IDLE: ignored; err_spurious sets.
  - tx_busy = (state==BUSY). A new tx_req is accepted on the cycle after return to IDLE.
- Errors: err_clr clears both flags. A new error event in the same cycle as err_clr leaves the flag set (set wins).
- sys_rst mid-operation: all in-flight slots, queue contents and TX state are discarded and outputs return to reset values on the next edge. A MAC rx_done or phy_tx_done arriving after reset counts as spurious.
- Width rules: counts are copied unmodified at CW bits, with no arithmetic. arm_slot is always in range because NSLOTS = 2**SLOT_BITS.

Test Plan:
1. SLOT_BITS=2. Arm slot 2; rx_done[2] with count 0x05E -> rx_ready=0100 one cycle after arm; cpl_valid 2 cycles after done with cpl_slot=2, cpl_count=0x05E; after ack, slot 2 re-armable with err_arm=0.
2. Arm all 4 slots; rx_done=1010 in one cycle with counts 100/200 -> queue order slot 1 (100), then slot 3 (200); then rx_done[0] -> third entry slot 0; cpl_valid stays high through 3 acks, then drops.
3. Arm slot 0 twice -> err_arm=1, slot stays ARMED. rx_done[1] while slot 1 FREE -> err_spurious=1, no queue entry. err_clr coincident with a new arm error -> err_arm remains 1.
4. Pop slot 0 while arming slot 0 in the same cycle -> slot 0 ARMED, rx_ready[0]=1, no error. Fill and drain the queue 3 times -> head pointer wraps, order preserved.
5. TX: tx_req with tx_len=1514 -> phy_tx_start single pulse, phy_tx_count=1514, tx_busy=1. tx_req with 60 while busy -> ignored, count stays 1514. phy_tx_done -> tx_event 1-cycle, irq pulse, tx_busy=0. tx_req with len 0 -> no start.
6. Assert sys_rst with 2 slots queued and TX busy -> all outputs 0 next cycle. A following phy_tx_done -> err_spurious=1 and no tx_event.
